// File: rtl/iter_div_pkg.sv
// Shared definitions for the iterative MIPS DIV/DIVU unit: widths, FSM encoding
// and the decode helper that turns a funct code into the divider's sign input.
package iter_div_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    ZERO = 2'd3
  } div_state_t;

  // MIPS SPECIAL funct codes for the two divide instructions
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

  function automatic logic is_signed_div(input logic [5:0] funct);
    return funct == FUNCT_DIV;
  endfunction

endpackage

// File: rtl/iter_div_if.sv
// Operand/result handshake between decode/control and the iterative divider.
interface iter_div_if
  import iter_div_pkg::*;
#(
  parameter int unsigned W = DIV_W
);
  logic         start;
  logic         sign;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         dz;

  modport master (
    output start, sign, a, b,
    input  q, r, busy, done, dz
  );

  modport slave (
    input  start, sign, a, b,
    output q, r, busy, done, dz
  );
endinterface

// File: rtl/iter_div_step.sv
// One restoring shift-subtract iteration; the partial remainder is widened by a
// bit so the compare and subtract never drop the carry out of the shift.
module iter_div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] rem_sh;
  logic       fits;

  always_comb begin
    rem_sh   = {rem, quo[W-1]};
    fits     = rem_sh >= {1'b0, divisor};
    rem_next = fits ? W'(rem_sh - {1'b0, divisor}) : rem_sh[W-1:0];
    quo_next = {quo[W-2:0], fits};
  end

endmodule

// File: rtl/iter_div.sv
// Multi-cycle signed/unsigned divider: magnitudes are divided by a restoring
// iteration, then signs are fixed up so q truncates toward zero and r follows a.
module iter_div
  import iter_div_pkg::*;
#(
  parameter int unsigned W     = DIV_W,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  iter_div_if.slave  bus
);

  div_state_t     state;
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   dvs;
  logic [CNT_W-1:0] cnt;
  logic           neg_q;
  logic           neg_r;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic [W-1:0]   rem_nx;
  logic [W-1:0]   quo_nx;

  always_comb begin
    abs_a = (bus.sign && bus.a[W-1]) ? -bus.a : bus.a;
    abs_b = (bus.sign && bus.b[W-1]) ? -bus.b : bus.b;
  end

  iter_div_step #(.W(W)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      bus.q    <= '0;
      bus.r    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.dz   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle still belongs to the finishing op, so start is refused there
          if (bus.start && !bus.done) begin
            neg_q <= bus.sign & (bus.a[W-1] ^ bus.b[W-1]);
            neg_r <= bus.sign & bus.a[W-1];
            dvs   <= abs_b;
            rem   <= '0;
            cnt   <= '0;
            if (bus.b == '0) begin
              quo   <= bus.a;
              state <= ZERO;
            end else begin
              quo      <= abs_a;
              bus.busy <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(W - 1)) begin
            bus.busy <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.q    <= neg_q ? -quo : quo;
          bus.r    <= neg_r ? -rem : rem;
          bus.dz   <= 1'b0;
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        ZERO: begin
          // quo still holds the raw dividend captured at start
          bus.q    <= '1;
          bus.r    <= quo;
          bus.dz   <= 1'b1;
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Bench for iter_div: directed MIPS divide cases plus random operands checked
// against plain integer division in a reference model.
module tb_iter_div;
  import iter_div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  iter_div_if #(.W(DIV_W)) bus ();

  iter_div #(.W(DIV_W), .CNT_W(DIV_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit signed arithmetic truncates toward zero and gives the
  // remainder the dividend's sign; the overflow case wraps on truncation.
  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eq, output logic [31:0] er, output logic edz);
    longint sa, sb;
    edz = 1'b0;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = a; edz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eq = 32'(sa / sb);
      er = 32'(sa % sb);
    end else begin
      eq = a / b;
      er = a % b;
    end
  endtask

  // Issues one op in the next free cycle and waits (bounded) for done.
  // lat counts rising edges after the accepting edge until done is visible.
  task automatic run_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] oq, output logic [31:0] orr, output logic odz,
                        output int lat, output int bcnt, output bit tout);
    @(negedge clk);
    bus.start = 1'b1; bus.sign = s; bus.a = av; bus.b = bv;
    @(posedge clk);
    tout = 1'b1; lat = 0; bcnt = 0; oq = '0; orr = '0; odz = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        oq = bus.q; orr = bus.r; odz = bus.dz; lat = i - 1; tout = 1'b0;
        break;
      end
      if (i == 1) begin
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.sign = 1'($urandom);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.sign = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.q, bus.r, bus.busy, bus.done, bus.dz} !== '0) begin
      miscompares++;
      $display("FAIL reset: q=%h r=%h busy=%b done=%b dz=%b, want all zero",
               bus.q, bus.r, bus.busy, bus.done, bus.dz);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_divu();
    logic [31:0] q, r; logic dz; int lat, bc; bit to;
    run_op(is_signed_div(FUNCT_DIVU), 32'd100, 32'd7, q, r, dz, lat, bc, to);
    vectors++;
    if (to || {q, r, dz} !== {32'd14, 32'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL divu_100_7: timeout=%0b q=%h r=%h dz=%b, want q=0000000e r=00000002 dz=0", to, q, r, dz);
    end
    vectors++;
    if (lat !== 33 || bc !== 32) begin
      miscompares++;
      $display("FAIL divu_latency: done after %0d edges busy %0d cycles, want 33 and 32", lat, bc);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.q !== 32'd14) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b q=%h one cycle later, want done=0 q held 0000000e", bus.done, bus.q);
    end
  endtask

  task automatic test_div_signed();
    logic [31:0] q, r; logic dz; int lat, bc; bit to;
    run_op(is_signed_div(FUNCT_DIV), 32'hFFFF_FFF9, 32'd2, q, r, dz, lat, bc, to);
    vectors++;
    if (to || {q, r, dz} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}) begin
      miscompares++;
      $display("FAIL div_m7_2: q=%h r=%h dz=%b, want q=fffffffd r=ffffffff dz=0", q, r, dz);
    end
    run_op(is_signed_div(FUNCT_DIV), 32'd7, 32'hFFFF_FFFE, q, r, dz, lat, bc, to);
    vectors++;
    if (to || {q, r, dz} !== {32'hFFFF_FFFD, 32'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL div_7_m2: q=%h r=%h dz=%b, want q=fffffffd r=00000001 dz=0", q, r, dz);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r; logic dz; int lat, bc; bit to;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, lat, bc, to);
    vectors++;
    if (to || {q, r, dz} !== {32'h8000_0000, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL div_overflow: q=%h r=%h dz=%b, want q=80000000 r=00000000 dz=0", q, r, dz);
    end
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, lat, bc, to);
    vectors++;
    if (to || {q, r, dz} !== {32'd0, 32'h8000_0000, 1'b0}) begin
      miscompares++;
      $display("FAIL divu_big: q=%h r=%h dz=%b, want q=00000000 r=80000000 dz=0", q, r, dz);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r; logic dz; int lat, bc; bit to;
    for (int s = 0; s < 2; s++) begin
      run_op(1'(s), 32'd5, 32'd0, q, r, dz, lat, bc, to);
      vectors++;
      if (to || {q, r, dz} !== {32'hFFFF_FFFF, 32'd5, 1'b1} || lat !== 1 || bc !== 0) begin
        miscompares++;
        $display("FAIL div_zero sign=%0d: q=%h r=%h dz=%b lat=%0d busy=%0d, want ffffffff 00000005 1 lat=1 busy=0",
                 s, q, r, dz, lat, bc);
      end
    end
  endtask

  task automatic test_ignore_mid();
    int lat; bit seen; logic [31:0] q, r;
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b0; bus.a = 32'd1000; bus.b = 32'd10;
    @(posedge clk);
    seen = 1'b0; lat = 0; q = '0; r = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; lat = i - 1; q = bus.q; r = bus.r; break; end
      bus.start = (i == 10);
      if (i == 10) begin bus.a = 32'd77; bus.b = 32'd5; bus.sign = 1'b1; end
    end
    bus.start = 1'b0;
    vectors++;
    if (!seen || lat !== 33 || q !== 32'd100 || r !== 32'd0) begin
      miscompares++;
      $display("FAIL ignore_mid_start: seen=%0b lat=%0d q=%h r=%h, want lat=33 q=00000064 r=00000000",
               seen, lat, q, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eq2, er2; logic edz2;
    int lat1, lat2; bit seen1, seen2, busy_after;
    logic [31:0] q1, r1, q2, r2;
    ref_div(1'b1, 32'hFFFF_FFEC, 32'd3, eq2, er2, edz2);
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b0; bus.a = 32'd50; bus.b = 32'd6;
    @(posedge clk);
    seen1 = 1'b0; seen2 = 1'b0; lat1 = 0; lat2 = 0; busy_after = 1'b1;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.done) begin seen1 = 1'b1; lat1 = i - 1; q1 = bus.q; r1 = bus.r; break; end
      if (i == 1) begin bus.sign = 1'b1; bus.a = 32'hFFFF_FFEC; bus.b = 32'd3; end
    end
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (j == 1) busy_after = bus.busy;
      if (bus.done) begin seen2 = 1'b1; lat2 = j; q2 = bus.q; r2 = bus.r; break; end
    end
    bus.start = 1'b0;
    vectors++;
    if (!seen1 || lat1 !== 33 || q1 !== 32'd8 || r1 !== 32'd2) begin
      miscompares++;
      $display("FAIL held_first: seen=%0b lat=%0d q=%h r=%h, want lat=33 q=00000008 r=00000002", seen1, lat1, q1, r1);
    end
    vectors++;
    if (busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL held_done_cycle: busy=%b after done cycle, want 0 (start in done cycle refused)", busy_after);
    end
    vectors++;
    if (!seen2 || lat2 !== 35 || q2 !== eq2 || r2 !== er2) begin
      miscompares++;
      $display("FAIL held_second: seen=%0b gap=%0d q=%h r=%h, want gap=35 q=%h r=%h", seen2, lat2, q2, r2, eq2, er2);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r; logic dz; int lat, bc; bit to; logic busy_pre;
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b0; bus.a = 32'd1000; bus.b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    busy_pre = bus.busy;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy_pre !== 1'b1 || {bus.q, bus.r, bus.busy, bus.done, bus.dz} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: busy_before=%b q=%h r=%h busy=%b done=%b dz=%b, want busy_before=1 and all zero",
               busy_pre, bus.q, bus.r, bus.busy, bus.done, bus.dz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b done=%b after release, want 0 0", bus.busy, bus.done);
    end
    run_op(1'b1, 32'd9, 32'd3, q, r, dz, lat, bc, to);
    vectors++;
    if (to || {q, r, dz} !== {32'd3, 32'd0, 1'b0} || lat !== 33) begin
      miscompares++;
      $display("FAIL after_reset_9_3: q=%h r=%h dz=%b lat=%0d, want 00000003 00000000 0 lat=33", q, r, dz, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er; logic s, dz, edz; int lat, bc; bit to;
    for (int n = 0; n < 40; n++) begin
      s = 1'($urandom);
      a = (($urandom % 8) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'h8000_0000 | 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      ref_div(s, a, b, eq, er, edz);
      run_op(s, a, b, q, r, dz, lat, bc, to);
      vectors++;
      if (to || {q, r, dz} !== {eq, er, edz} || lat !== (edz ? 1 : 33)) begin
        miscompares++;
        $display("FAIL random sign=%b a=%h b=%h: q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
                 s, a, b, q, r, dz, lat, eq, er, edz, edz ? 1 : 33);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_overflow();
    test_div_zero();
    test_ignore_mid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
